round_timer: RTL and testbench

ROUND_TIMER -- requirements
Module: round_timer

---
 rtl/game_pkg.sv | 35 +++
 rtl/round_timer_tick_prescaler.sv | 46 ++++
 rtl/round_timer.sv | 132 +++++++++++++
 tb/tb_round_timer.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared game definitions: state encoding, controller mode codes and round
// limits. The game controller reuses the mode codes from here.
package game_pkg;

  localparam int unsigned SEC_W = 7;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PAUSED  = 2'd1,
    ST_RUNNING = 2'd2,
    ST_EXPIRED = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    MODE_30     = 2'b00,
    MODE_60     = 2'b01,
    MODE_90     = 2'b10,
    MODE_LOGOUT = 2'b11
  } mode_e;

  localparam logic [SEC_W-1:0] LIMIT_30 = SEC_W'(30);
  localparam logic [SEC_W-1:0] LIMIT_60 = SEC_W'(60);
  localparam logic [SEC_W-1:0] LIMIT_90 = SEC_W'(90);

  // Round length for a load code; the logout code carries no time.
  function automatic logic [SEC_W-1:0] mode_limit(input logic [1:0] mode);
    case (mode)
      MODE_30: return LIMIT_30;
      MODE_60: return LIMIT_60;
      MODE_90: return LIMIT_90;
      default: return '0;
    endcase
  endfunction

endpackage

// File: rtl/round_timer_tick_prescaler.sv
// tick_prescaler: divides clk down to a one-second wrap strobe.
// Ports:
//   clk   - system clock
//   rst   - synchronous active-high reset, clears the count
//   clear - synchronous clear (restart of a round), beats run
//   run   - advance the count this cycle
//   wrap  - high in the cycle the count sits at TICK_CYCLES-1 while running;
//           the count returns to 0 on the following edge
module tick_prescaler #(
  parameter int unsigned TICK_CYCLES = 100000000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic run,
  output logic wrap
);

  // Minimum width that holds TICK_CYCLES-1.
  localparam int unsigned CNT_W = (TICK_CYCLES > 2) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign wrap = run && (cnt_q == LAST);

  // Next count: clear wins, otherwise count only while running.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (run) begin
      cnt_d = wrap ? '0 : cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/round_timer.sv
// round_timer: per-round countdown for the game controller.
// Ports:
//   clk           - system clock, rising edge
//   rst           - synchronous active-high reset, overrides everything
//   ReconfigTimer - one-cycle load strobe; mode selects 30/60/90 s or unload
//   mode          - limit select, sampled only with ReconfigTimer
//   enable        - level: high runs the countdown, low pauses it
//   Timeout       - high while the round has expired
//   seconds_left  - remaining whole seconds
//   tick          - one-cycle pulse after each one-second decrement
//   Warning       - high while paused/running with 0 < seconds_left <= WARN_SECS
module round_timer
  import game_pkg::*;
#(
  parameter int unsigned TICK_CYCLES = 100000000,
  parameter int unsigned WARN_SECS   = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ReconfigTimer,
  input  logic [1:0]       mode,
  input  logic             enable,
  output logic             Timeout,
  output logic [SEC_W-1:0] seconds_left,
  output logic             tick,
  output logic             Warning
);

  localparam int unsigned SEC_MAX = (1 << SEC_W) - 1;
  localparam logic [SEC_W-1:0] WARN_LVL =
    (WARN_SECS > SEC_MAX) ? SEC_W'(SEC_MAX) : SEC_W'(WARN_SECS);

  state_e           state_q;
  logic [SEC_W-1:0] sec_q;
  logic [SEC_W-1:0] sec_dec;
  logic             tick_q;
  logic             timeout_q;
  logic             warn_q;
  logic             run;
  logic             wrap;

  function automatic logic warn_for(input logic [SEC_W-1:0] s);
    return (s != '0) && (s <= WARN_LVL);
  endfunction

  // Prescaler advances only on cycles that actually count down, so a pause
  // (including the cycle that drops into PAUSED) leaves its phase untouched.
  assign run = (state_q == ST_RUNNING) && enable;

  tick_prescaler #(
    .TICK_CYCLES (TICK_CYCLES)
  ) u_prescaler (
    .clk   (clk),
    .rst   (rst),
    .clear (ReconfigTimer),
    .run   (run),
    .wrap  (wrap)
  );

  assign sec_dec = sec_q - SEC_W'(1);

  // Round FSM with registered outputs; reload beats every other event.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      sec_q     <= '0;
      tick_q    <= 1'b0;
      timeout_q <= 1'b0;
      warn_q    <= 1'b0;
    end else if (ReconfigTimer) begin
      tick_q    <= 1'b0;
      timeout_q <= 1'b0;
      if (mode == MODE_LOGOUT) begin
        state_q <= ST_IDLE;
        sec_q   <= '0;
        warn_q  <= 1'b0;
      end else begin
        state_q <= ST_PAUSED;
        sec_q   <= mode_limit(mode);
        warn_q  <= warn_for(mode_limit(mode));
      end
    end else begin
      tick_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          sec_q     <= '0;
          timeout_q <= 1'b0;
          warn_q    <= 1'b0;
        end
        ST_PAUSED: begin
          if (enable) begin
            state_q <= ST_RUNNING;
          end
          warn_q <= warn_for(sec_q);
        end
        ST_RUNNING: begin
          if (!enable) begin
            state_q <= ST_PAUSED;
          end else if (wrap && (sec_q != '0)) begin
            // Last decrement lands in EXPIRED on the same edge.
            sec_q  <= sec_dec;
            tick_q <= 1'b1;
            if (sec_dec == '0) begin
              state_q   <= ST_EXPIRED;
              timeout_q <= 1'b1;
              warn_q    <= 1'b0;
            end else begin
              warn_q <= warn_for(sec_dec);
            end
          end
        end
        ST_EXPIRED: begin
          sec_q     <= '0;
          timeout_q <= 1'b1;
          warn_q    <= 1'b0;
        end
        default: begin
          state_q   <= ST_IDLE;
          sec_q     <= '0;
          timeout_q <= 1'b0;
          warn_q    <= 1'b0;
        end
      endcase
    end
  end

  assign Timeout      = timeout_q;
  assign seconds_left = sec_q;
  assign tick         = tick_q;
  assign Warning      = warn_q;

endmodule

// File: tb/tb_round_timer.sv
// Bench for round_timer with TICK_CYCLES=4, WARN_SECS=5. Each cycle's
// expected outputs are queued when its inputs are driven and checked after
// the following rising edge.
module tb_round_timer;

  localparam int unsigned TC = 4;
  localparam int unsigned WS = 5;

  logic       clk;
  logic       rst;
  logic       cfg;
  logic [1:0] mode;
  logic       en;
  logic       timeout;
  logic [6:0] secs;
  logic       tick;
  logic       warn;

  typedef struct packed {
    logic       to;
    logic [6:0] sec;
    logic       tick;
    logic       warn;
  } exp_t;

  typedef struct packed {
    logic       rst;
    logic       cfg;
    logic [1:0] mode;
    logic       en;
    logic       to;
    logic [6:0] sec;
    logic       tick;
    logic       warn;
  } vec_t;

  exp_t sbq[$];
  vec_t tbl[6];
  int   n_total = 0;
  int   n_bad   = 0;

  round_timer #(
    .TICK_CYCLES (TC),
    .WARN_SECS   (WS)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .ReconfigTimer (cfg),
    .mode          (mode),
    .enable        (en),
    .Timeout       (timeout),
    .seconds_left  (secs),
    .tick          (tick),
    .Warning       (warn)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input int got, input int want);
    n_total++;
    if (got != want) begin
      n_bad++;
      $display("FAIL %s got=%0d want=%0d", nm, got, want);
    end
  endtask

  // Drive one cycle of inputs, queue its expectation, check after the edge.
  task automatic cyc(input logic r, input logic c, input logic [1:0] m,
                     input logic e, input logic xto, input logic [6:0] xsec,
                     input logic xtick, input logic xwarn, input string tag);
    exp_t ex;
    rst  = r;
    cfg  = c;
    mode = m;
    en   = e;
    ex.to   = xto;
    ex.sec  = xsec;
    ex.tick = xtick;
    ex.warn = xwarn;
    sbq.push_back(ex);
    @(posedge clk);
    #1;
    ex = sbq.pop_front();
    chk({tag, " Timeout"},      int'(timeout), int'(ex.to));
    chk({tag, " seconds_left"}, int'(secs),    int'(ex.sec));
    chk({tag, " tick"},         int'(tick),    int'(ex.tick));
    chk({tag, " Warning"},      int'(warn),    int'(ex.warn));
  endtask

  // n enabled cycles in RUNNING; prescaler phase pre0, starting at sec0.
  task automatic run_n(input int n, input int sec0, input int pre0, input string tag);
    for (int k = 1; k <= n; k++) begin
      int p;
      int s;
      p = pre0 + k;
      s = sec0 - p / int'(TC);
      if (s < 0) s = 0;
      cyc(1'b0, 1'b0, 2'b00, 1'b1, s == 0, 7'(s), (p % int'(TC)) == 0,
          (s > 0) && (s <= int'(WS)), $sformatf("%s k=%0d", tag, k));
    end
  endtask

  initial begin
    rst  = 1'b1;
    cfg  = 1'b0;
    mode = 2'b00;
    en   = 1'b0;

    //          rst   cfg   mode   en    to    sec     tick  warn
    tbl[0] = '{1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 7'd0,  1'b0, 1'b0};
    tbl[1] = '{1'b1, 1'b1, 2'b00, 1'b1, 1'b0, 7'd0,  1'b0, 1'b0};
    tbl[2] = '{1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 7'd0,  1'b0, 1'b0};
    tbl[3] = '{1'b0, 1'b1, 2'b11, 1'b1, 1'b0, 7'd0,  1'b0, 1'b0};
    tbl[4] = '{1'b0, 1'b1, 2'b00, 1'b1, 1'b0, 7'd30, 1'b0, 1'b0};
    tbl[5] = '{1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 7'd30, 1'b0, 1'b0};

    // Reset, idle with enable, first load and start.
    for (int i = 0; i < 6; i++) begin
      cyc(tbl[i].rst, tbl[i].cfg, tbl[i].mode, tbl[i].en,
          tbl[i].to, tbl[i].sec, tbl[i].tick, tbl[i].warn, $sformatf("vec%0d", i));
      if (i == 3) begin
        for (int j = 0; j < 20; j++)
          cyc(1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 7'd0, 1'b0, 1'b0, $sformatf("idle%0d", j));
      end
    end

    // Full 30 s round to expiry, then EXPIRED holds regardless of enable.
    run_n(120, 30, 0, "run30");
    for (int j = 0; j < 5; j++)
      cyc(1'b0, 1'b0, 2'b00, j < 3, 1'b1, 7'd0, 1'b0, 1'b0, $sformatf("expired%0d", j));

    // Reload from EXPIRED with 90 s.
    cyc(1'b0, 1'b1, 2'b10, 1'b0, 1'b0, 7'd90, 1'b0, 1'b0, "exp_reload");
    cyc(1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 7'd90, 1'b0, 1'b0, "exp_reload_hold");

    // 60 s: run 10, pause 20, resume; next decrement 2 running cycles later.
    cyc(1'b0, 1'b1, 2'b01, 1'b0, 1'b0, 7'd60, 1'b0, 1'b0, "load60");
    cyc(1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 7'd60, 1'b0, 1'b0, "start60");
    run_n(10, 60, 0, "run60");
    for (int j = 0; j < 20; j++)
      cyc(1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 7'd58, 1'b0, 1'b0, $sformatf("pause%0d", j));
    cyc(1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 7'd58, 1'b0, 1'b0, "resume");
    run_n(2, 58, 2, "after_resume");
    run_n(3, 57, 0, "to_due");

    // Reload on the cycle a tick is due: tick discarded, phase cleared.
    cyc(1'b0, 1'b1, 2'b10, 1'b1, 1'b0, 7'd90, 1'b0, 1'b0, "reload_on_tick");
    cyc(1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 7'd90, 1'b0, 1'b0, "reload_hold");
    cyc(1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 7'd90, 1'b0, 1'b0, "reload_start");
    run_n(4, 90, 0, "run90");

    // Unload while running at 12.
    cyc(1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 7'd30, 1'b0, 1'b0, "load30b");
    cyc(1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 7'd30, 1'b0, 1'b0, "start30b");
    run_n(72, 30, 0, "to12");
    cyc(1'b0, 1'b1, 2'b11, 1'b1, 1'b0, 7'd0, 1'b0, 1'b0, "unload");
    for (int j = 0; j < 5; j++)
      cyc(1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 7'd0, 1'b0, 1'b0, $sformatf("unloaded%0d", j));

    // Warning while paused, then reset at 3 s aborts the round.
    cyc(1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 7'd30, 1'b0, 1'b0, "load30c");
    cyc(1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 7'd30, 1'b0, 1'b0, "start30c");
    run_n(108, 30, 0, "to3");
    cyc(1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 7'd3, 1'b0, 1'b1, "pause_warn");
    cyc(1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 7'd3, 1'b0, 1'b1, "resume_warn");
    run_n(2, 3, 0, "near_end");
    cyc(1'b1, 1'b0, 2'b00, 1'b1, 1'b0, 7'd0, 1'b0, 1'b0, "rst_mid");
    for (int j = 0; j < 20; j++)
      cyc(1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 7'd0, 1'b0, 1'b0, $sformatf("post_rst%0d", j));

    chk("scoreboard_drained", sbq.size(), 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
